// File: rtl/adc_emulator_pkg.sv
// Shared constants and FSM encoding for the serial ADC responder.
// The module parameters default to the constants below.
package adc_emulator_pkg;

  localparam int WIDTH_DEF      = 12;
  localparam int LEAD_ZEROS_DEF = 4;
  localparam int FRAME_BITS     = LEAD_ZEROS_DEF + WIDTH_DEF;
  localparam int BITCNT_W       = $clog2(FRAME_BITS + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/adc_emulator_sample_fifo.sv
// Small sample queue feeding the ADC responder.
// A push is accepted when full only if a pop happens in the same cycle.
module sample_fifo #(
  parameter int WIDTH = 12,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic             wr_en_s;
  logic             rd_en_s;

  assign full    = (count_r == CNT_W'(DEPTH));
  assign empty   = (count_r == CNT_W'(0));
  assign head    = mem_r[rd_ptr_r];
  assign wr_en_s = push & (~full | pop);
  assign rd_en_s = pop & ~empty;

  // Storage, pointers and occupancy; pointers wrap because DEPTH is a power of 2.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_r[i] <= '0;
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (wr_en_s) begin
        mem_r[wr_ptr_r] <= din;
        wr_ptr_r        <= wr_ptr_r + PTR_W'(1);
      end
      if (rd_en_s) rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CNT_W'(1);
        2'b01:   count_r <= count_r - CNT_W'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/adc_emulator.sv
// Responder end of the adc_clk/adc_cs/adc_sd link: synchronises the master's
// strobes into clk and shifts queued samples out MSB first behind leading zeros.
module adc_emulator
  import adc_emulator_pkg::*;
#(
  parameter int WIDTH       = WIDTH_DEF,
  parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
  parameter int DEPTH       = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             adc_clk,
  input  logic             adc_cs,
  output logic             adc_sd,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             frame_done,
  output logic             aborted,
  output logic             underrun
);

  localparam int FRAME_LEN = LEAD_ZEROS + WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);

  logic [SYNC_STAGES-1:0] cs_sync_r;
  logic [SYNC_STAGES-1:0] sclk_sync_r;
  logic                   cs_prev_r;
  logic                   sclk_prev_r;
  logic                   cs_s;
  logic                   sclk_s;
  logic                   cs_fall_s;
  logic                   cs_rise_s;
  logic                   sclk_fall_s;

  state_t                 state_r;
  logic [FRAME_LEN-1:0]   shreg_r;
  logic [FRAME_LEN-1:0]   load_s;
  logic [CNT_W-1:0]       bitcnt_r;
  logic [WIDTH-1:0]       last_sample_r;
  logic                   sd_r;
  logic                   done_r;
  logic                   abort_r;
  logic                   under_r;

  logic [WIDTH-1:0]       head_s;
  logic                   full_s;
  logic                   empty_s;
  logic                   push_s;
  logic                   pop_s;

  assign cs_s        = cs_sync_r[SYNC_STAGES-1];
  assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
  assign cs_fall_s   = cs_prev_r & ~cs_s;
  assign cs_rise_s   = ~cs_prev_r & cs_s;
  assign sclk_fall_s = sclk_prev_r & ~sclk_s;

  // The frame-start pop frees a slot, so a waiting push may land in that same cycle.
  assign in_ready    = ~full_s | pop_s;
  assign push_s      = in_valid & in_ready;

  assign adc_sd      = sd_r;
  assign frame_done  = done_r;
  assign aborted     = abort_r;
  assign underrun    = under_r;

  sample_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push_s),
    .pop   (pop_s),
    .din   (in_data),
    .head  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Synchronisers and edge-detect history, idling at the bus-idle level (high).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cs_sync_r   <= '1;
      sclk_sync_r <= '1;
      cs_prev_r   <= 1'b1;
      sclk_prev_r <= 1'b1;
    end else begin
      cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], adc_cs};
      sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], adc_clk};
      cs_prev_r   <= cs_s;
      sclk_prev_r <= sclk_s;
    end
  end

  // Frame load: fresh FIFO head when available, otherwise repeat the last sample.
  always_comb begin
    pop_s  = 1'b0;
    load_s = FRAME_LEN'(last_sample_r);
    if ((state_r == IDLE) && cs_fall_s && !empty_s) begin
      pop_s  = 1'b1;
      load_s = FRAME_LEN'(head_s);
    end else begin
      pop_s  = 1'b0;
    end
  end

  // Frame FSM; an abort (cs_rise) takes priority over a same-cycle shift.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= IDLE;
      shreg_r       <= '0;
      bitcnt_r      <= '0;
      last_sample_r <= '0;
      sd_r          <= 1'b0;
      done_r        <= 1'b0;
      abort_r       <= 1'b0;
      under_r       <= 1'b0;
    end else begin
      done_r  <= 1'b0;
      abort_r <= 1'b0;
      under_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (cs_fall_s) begin
            shreg_r  <= load_s;
            bitcnt_r <= '0;
            sd_r     <= load_s[FRAME_LEN-1];
            under_r  <= empty_s;
            state_r  <= SHIFT;
            if (!empty_s) last_sample_r <= head_s;
          end
        end
        SHIFT: begin
          if (cs_rise_s) begin
            sd_r    <= 1'b0;
            abort_r <= 1'b1;
            state_r <= IDLE;
          end else if (sclk_fall_s) begin
            if (bitcnt_r == CNT_W'(FRAME_LEN - 1)) begin
              sd_r     <= 1'b0;
              done_r   <= 1'b1;
              bitcnt_r <= CNT_W'(FRAME_LEN);
              state_r  <= DONE;
            end else begin
              shreg_r  <= {shreg_r[FRAME_LEN-2:0], 1'b0};
              bitcnt_r <= bitcnt_r + CNT_W'(1);
              sd_r     <= shreg_r[FRAME_LEN-2];
            end
          end
        end
        DONE: begin
          sd_r <= 1'b0;
          if (cs_rise_s) state_r <= IDLE;
        end
        default: begin
          sd_r    <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_emulator.sv
// Directed bench for adc_emulator: a behavioural SPI master captures adc_sd
// before each rising adc_clk and checks frames, pulses and FIFO back-pressure.
module tb_adc_emulator;

  logic        clk;
  logic        reset;
  logic        adc_clk;
  logic        adc_cs;
  logic        adc_sd;
  logic [11:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        frame_done;
  logic        aborted;
  logic        underrun;

  int n_checks = 0;
  int n_fail   = 0;
  int acc_cnt  = 0;
  int done_cnt = 0;
  int abort_cnt = 0;
  int under_cnt = 0;

  adc_emulator dut (
    .clk        (clk),
    .reset      (reset),
    .adc_clk    (adc_clk),
    .adc_cs     (adc_cs),
    .adc_sd     (adc_sd),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .frame_done (frame_done),
    .aborted    (aborted),
    .underrun   (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Handshake and pulse counters observed independently of the stimulus.
  always @(posedge clk) if (in_valid && in_ready) acc_cnt <= acc_cnt + 1;
  always @(negedge clk) begin
    if (frame_done) done_cnt  <= done_cnt + 1;
    if (aborted)    abort_cnt <= abort_cnt + 1;
    if (underrun)   under_cnt <= under_cnt + 1;
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input logic [11:0] d);
    int base;
    base     = acc_cnt;
    in_data  = d;
    in_valid = 1'b1;
    for (int i = 0; i < 16 && acc_cnt == base; i++) @(negedge clk);
    in_valid = 1'b0;
    check("push_accept", 16'(acc_cnt - base), 16'd1);
  endtask

  task automatic frame_start();
    adc_clk = 1'b0;
    wait_clk(8);
    adc_cs = 1'b0;
    wait_clk(8);
  endtask

  task automatic frame_bits(input int n, output logic [15:0] cap);
    cap = '0;
    for (int k = 0; k < n; k++) begin
      cap = {cap[14:0], adc_sd};
      adc_clk = 1'b1;
      wait_clk(8);
      adc_clk = 1'b0;
      wait_clk(8);
    end
  endtask

  task automatic frame_end();
    adc_cs  = 1'b1;
    adc_clk = 1'b1;
    wait_clk(8);
  endtask

  logic [15:0] cap;
  logic [11:0] vec [3];
  int d0, u0, a0, acc0;

  initial begin
    reset    = 1'b1;
    adc_clk  = 1'b1;
    adc_cs   = 1'b1;
    in_valid = 1'b0;
    in_data  = 12'h000;
    wait_clk(3);
    check("rst_sd",       16'(adc_sd),     16'd0);
    check("rst_in_ready", 16'(in_ready),   16'd1);
    check("rst_done",     16'(frame_done), 16'd0);
    check("rst_abort",    16'(aborted),    16'd0);
    check("rst_under",    16'(underrun),   16'd0);
    reset = 1'b0;
    wait_clk(2);

    // Single frame
    push(12'hA5C);
    d0 = done_cnt; u0 = under_cnt;
    frame_start();
    frame_bits(16, cap);
    check("t1_frame", cap, 16'h0A5C);
    check("t1_sd_idle", 16'(adc_sd), 16'd0);
    check("t1_done", 16'(done_cnt - d0), 16'd1);
    check("t1_under", 16'(under_cnt - u0), 16'd0);
    frame_end();

    // Back-to-back frames in order
    vec[0] = 12'hFFF; vec[1] = 12'h001; vec[2] = 12'h800;
    for (int i = 0; i < 3; i++) push(vec[i]);
    for (int i = 0; i < 3; i++) begin
      frame_start();
      frame_bits(16, cap);
      frame_end();
      check("t2_frame", cap, 16'(vec[i]));
    end

    // Underrun repeats the last sample
    u0 = under_cnt;
    frame_start();
    check("t3_under", 16'(under_cnt - u0), 16'd1);
    frame_bits(16, cap);
    frame_end();
    check("t3_frame", cap, 16'h0800);

    // Abort after 7 falling edges
    push(12'hABC);
    push(12'h456);
    a0 = abort_cnt; d0 = done_cnt;
    frame_start();
    frame_bits(7, cap);
    frame_end();
    check("t4_partial", cap, 16'h0005);
    check("t4_abort", 16'(abort_cnt - a0), 16'd1);
    check("t4_no_done", 16'(done_cnt - d0), 16'd0);
    check("t4_sd", 16'(adc_sd), 16'd0);
    frame_start();
    frame_bits(16, cap);
    frame_end();
    check("t4_next", cap, 16'h0456);

    // FIFO full back-pressure and same-cycle pop/push
    for (int i = 0; i < 4; i++) push(12'(12'h111 * (i + 1)));
    acc0 = acc_cnt;
    in_data  = 12'h555;
    in_valid = 1'b1;
    wait_clk(4);
    check("t5_ready_full", 16'(in_ready), 16'd0);
    check("t5_refused", 16'(acc_cnt - acc0), 16'd0);
    frame_start();
    check("t5_pop_push", 16'(acc_cnt - acc0), 16'd1);
    check("t5_ready_again", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    frame_bits(16, cap);
    frame_end();
    check("t5_frame0", cap, 16'h0111);
    for (int i = 1; i < 5; i++) begin
      frame_start();
      frame_bits(16, cap);
      frame_end();
      check("t5_frame", cap, 16'(12'h111 * (i + 1)));
    end

    // Reset mid-frame
    push(12'h777);
    frame_start();
    frame_bits(5, cap);
    check("t6_sd_before", 16'(adc_sd), 16'd1);
    reset = 1'b1;
    #1;
    check("t6_sd_reset", 16'(adc_sd), 16'd0);
    check("t6_ready_reset", 16'(in_ready), 16'd1);
    adc_cs  = 1'b1;
    adc_clk = 1'b1;
    wait_clk(3);
    reset = 1'b0;
    wait_clk(4);
    u0 = under_cnt;
    frame_start();
    frame_bits(16, cap);
    frame_end();
    check("t6_under", 16'(under_cnt - u0), 16'd1);
    check("t6_frame", cap, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
